// File: rtl/grid_frame_loader.sv
`default_nettype none
// ============================================================================
//  Module   : grid_frame_loader
//  Brief    : Double-buffered wide-frame assembler. Narrow packed host
//             commands (commit | word index | payload) fill a back buffer;
//             a commit moves it onto a valid/ready frame output.
//  Revision : 1.0 - initial parametrised double-buffered release
// ============================================================================
module grid_frame_loader #(
    parameter  int FRAME_BITS      = 2500,
    parameter  int WORD_W          = 16,
    parameter  int ADDR_W          = 15,
    parameter  int CLEAR_ON_COMMIT = 1,
    localparam int NWORDS          = (FRAME_BITS + WORD_W - 1) / WORD_W,
    localparam int CMD_W           = 1 + ADDR_W + WORD_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CMD_W-1:0]      cmd_data,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    output logic [FRAME_BITS-1:0] frame_dout,
    output logic                  frame_valid,
    input  logic                  frame_ready,
    output logic                  frame_full,
    output logic                  err_oob
);

    // NWORDS held one bit wider than the index so the range check also
    // works when NWORDS equals 2**ADDR_W.
    localparam logic [ADDR_W:0] c_nwords = (ADDR_W + 1)'(NWORDS);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t                  r_state;
    logic [FRAME_BITS-1:0]   r_back;
    logic [NWORDS-1:0]       r_mask;

    logic                    w_commit_bit;
    logic [ADDR_W-1:0]       w_idx;
    logic [WORD_W-1:0]       w_payload;
    logic                    w_accept;
    logic                    w_in_range;
    logic                    w_wr;
    logic                    w_commit;
    logic [FRAME_BITS-1:0]   w_merged;
    logic [NWORDS-1:0]       w_mask_merged;

    assign w_commit_bit = cmd_data[CMD_W-1];
    assign w_idx        = cmd_data[WORD_W+ADDR_W-1:WORD_W];
    assign w_payload    = cmd_data[WORD_W-1:0];

    // A held, unconsumed frame blocks new commands; a consuming cycle frees them.
    assign cmd_ready  = ~frame_valid | frame_ready;
    assign w_accept   = cmd_valid & cmd_ready;
    assign w_in_range = ({1'b0, w_idx} < c_nwords);
    assign w_wr       = w_accept & w_in_range;
    assign w_commit   = w_accept & w_commit_bit;

    // Per-word merge of the incoming payload into the back buffer. The last
    // word is clipped at FRAME_BITS so surplus payload bits are dropped.
    for (genvar i = 0; i < NWORDS; i++) begin : g_word
        localparam int LO = i * WORD_W;
        localparam int HI = (LO + WORD_W > FRAME_BITS) ? FRAME_BITS - 1 : LO + WORD_W - 1;
        logic w_sel;
        assign w_sel               = w_wr && (w_idx == ADDR_W'(i));
        assign w_merged[HI:LO]     = w_sel ? w_payload[HI-LO:0] : r_back[HI:LO];
        assign w_mask_merged[i]    = r_mask[i] | w_sel;
    end

    // Back buffer, written-mask, sticky out-of-range flag and output frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_back     <= '0;
            r_mask     <= '0;
            err_oob    <= 1'b0;
            frame_dout <= '0;
            frame_full <= 1'b0;
        end else begin
            if (w_accept && !w_in_range) begin
                err_oob <= 1'b1;
            end
            if (w_commit) begin
                frame_dout <= w_merged;
                frame_full <= &w_mask_merged;
                r_mask     <= '0;
                if (CLEAR_ON_COMMIT != 0) begin
                    r_back <= '0;
                end else begin
                    r_back <= w_merged;
                end
            end else if (w_wr) begin
                r_back <= w_merged;
                r_mask <= w_mask_merged;
            end
        end
    end

    // Output-side FSM: EMPTY until a commit, FULL until consumed without a
    // simultaneous commit (handshake plus commit keeps it FULL, no bubble).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_EMPTY;
            frame_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_commit) begin
                        r_state     <= ST_FULL;
                        frame_valid <= 1'b1;
                    end
                end
                ST_FULL: begin
                    if (frame_ready && !w_commit) begin
                        r_state     <= ST_EMPTY;
                        frame_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ST_EMPTY;
                    frame_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_grid_frame_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_grid_frame_loader
//  Brief    : Directed self-checking bench for grid_frame_loader at default
//             parameters (2500-bit frame, 16-bit words, 157 words).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_grid_frame_loader;

    localparam int FB    = 2500;
    localparam int WW    = 16;
    localparam int AW    = 15;
    localparam int CMDW  = 1 + AW + WW;

    logic            clk;
    logic            rst;
    logic [CMDW-1:0] cmd_data;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [FB-1:0]   frame_dout;
    logic            frame_valid;
    logic            frame_ready;
    logic            frame_full;
    logic            err_oob;

    int n_assert = 0;
    int n_fail   = 0;

    logic [FB-1:0] exp_frame;
    logic [FB-1:0] held_frame;

    grid_frame_loader #(
        .FRAME_BITS      (FB),
        .WORD_W          (WW),
        .ADDR_W          (AW),
        .CLEAR_ON_COMMIT (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_data    (cmd_data),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .frame_dout  (frame_dout),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .frame_full  (frame_full),
        .err_oob     (err_oob)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_frame(input string tag, input logic [FB-1:0] exp);
        int w;
        n_assert++;
        assert (frame_dout === exp) else begin
            n_fail++;
            w = 0;
            for (int k = 0; k < (FB + WW - 1) / WW; k++) begin
                if (frame_dout[k*WW +: WW] !== exp[k*WW +: WW]) begin
                    w = k;
                    break;
                end
            end
            $error("FAIL %s: word %0d observed %h expected %h", tag, w,
                   frame_dout[w*WW +: WW], exp[w*WW +: WW]);
        end
    endtask

    // Presents one command for exactly one edge; called #1 after a rising edge.
    task automatic send(input logic c, input int idx, input logic [WW-1:0] pl);
        cmd_data  = {c, AW'(idx), pl};
        cmd_valid = 1'b1;
        #1;
        check_bit("cmd_ready_at_send", cmd_ready, 1'b1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_data  = '0;
    endtask

    initial begin
        rst         = 1'b1;
        cmd_valid   = 1'b0;
        cmd_data    = '0;
        frame_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        check_bit("rst_frame_valid", frame_valid, 1'b0);
        check_bit("rst_frame_full", frame_full, 1'b0);
        check_bit("rst_err_oob", err_oob, 1'b0);
        check_bit("rst_cmd_ready", cmd_ready, 1'b1);
        check_frame("rst_frame_dout", '0);

        // Full frame: word k = k, commit on the last word (156 -> 0x9C, clipped to 4'hC)
        for (int k = 0; k < 157; k++) send(k == 156, k, WW'(k));
        exp_frame = '0;
        for (int k = 0; k < 156; k++) exp_frame[k*WW +: WW] = WW'(k);
        exp_frame[2499:2496] = 4'hC;
        check_bit("full_valid", frame_valid, 1'b1);
        check_bit("full_full", frame_full, 1'b1);
        check_frame("full_dout", exp_frame);
        @(posedge clk);
        #1;
        check_bit("full_consumed", frame_valid, 1'b0);

        // Partial frame after clear-on-commit
        send(1'b0, 0, 16'hAAAA);
        send(1'b1, 5, 16'h1234);
        exp_frame = '0;
        exp_frame[15:0]  = 16'hAAAA;
        exp_frame[95:80] = 16'h1234;
        check_bit("part_valid", frame_valid, 1'b1);
        check_bit("part_full", frame_full, 1'b0);
        check_frame("part_dout", exp_frame);

        // Backpressure: held frame stays stable, commands blocked
        frame_ready = 1'b0;
        held_frame  = exp_frame;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            check_bit("bp_cmd_ready", cmd_ready, 1'b0);
            check_bit("bp_valid", frame_valid, 1'b1);
            check_frame("bp_dout_stable", held_frame);
        end

        // Consume and commit in the same cycle: no bubble, new frame next cycle
        frame_ready = 1'b1;
        send(1'b1, 7, 16'h7777);
        exp_frame = '0;
        exp_frame[127:112] = 16'h7777;
        check_bit("b2b_valid", frame_valid, 1'b1);
        check_bit("b2b_full", frame_full, 1'b0);
        check_frame("b2b_dout", exp_frame);

        // Out-of-range index sets sticky error, buffer untouched
        send(1'b0, 200, 16'hFFFF);
        check_bit("oob_err", err_oob, 1'b1);
        check_bit("oob_no_frame", frame_valid, 1'b0);
        send(1'b1, 2, 16'h0002);
        exp_frame = '0;
        exp_frame[47:32] = 16'h0002;
        check_frame("oob_buffer_clean", exp_frame);
        check_bit("oob_err_sticky", err_oob, 1'b1);

        // Truncation of the final word
        send(1'b1, 156, 16'hFFFF);
        exp_frame = '0;
        exp_frame[2499:2496] = 4'hF;
        check_frame("trunc_dout", exp_frame);
        check_bit("trunc_full", frame_full, 1'b0);

        // Overwrite: last write wins; commit carried by an out-of-range index
        send(1'b0, 3, 16'h1111);
        send(1'b0, 3, 16'h2222);
        send(1'b1, 400, 16'h0000);
        exp_frame = '0;
        exp_frame[63:48] = 16'h2222;
        check_bit("ovw_valid", frame_valid, 1'b1);
        check_frame("ovw_dout", exp_frame);
        check_bit("ovw_err_sticky", err_oob, 1'b1);

        // Reset mid-fill discards the partial frame and clears the error
        for (int k = 0; k < 50; k++) send(1'b0, k, WW'(k + 1));
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_bit("midrst_valid", frame_valid, 1'b0);
        check_bit("midrst_err", err_oob, 1'b0);
        send(1'b1, 0, 16'h0000);
        check_bit("midrst_commit_valid", frame_valid, 1'b1);
        check_bit("midrst_full", frame_full, 1'b0);
        check_bit("midrst_err_after", err_oob, 1'b0);
        check_frame("midrst_dout", '0);

        @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
